bcd_display_ctrl: RTL and testbench

BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

---
 rtl/bcd_display_ctrl.sv | 148 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// Switch-driven 4-digit seven-segment controller: converts SW[11:0] to BCD
// (shift-and-add-3) or hex digits and latches the glyphs once per conversion.
module bcd_display_ctrl #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] SW,
    output logic [6:0]  HEX_0,
    output logic [6:0]  HEX_1,
    output logic [6:0]  HEX_2,
    output logic [6:0]  HEX_3,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam logic [6:0] BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t      state, state_nxt;
    logic [12:0] key, key_nxt;
    logic        key_valid, key_valid_nxt;
    logic [11:0] value, value_nxt;
    logic [15:0] bcd, bcd_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic        busy_nxt, done_nxt;
    logic [6:0]  hex0_nxt, hex1_nxt, hex2_nxt, hex3_nxt;

    logic [12:0] sw_key;
    logic [15:0] digits;
    logic        sw_unused;

    assign sw_key    = {SW[14], SW[11:0]};
    assign sw_unused = &{1'b0, SW[13:12]};

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return SEG_ACTIVE_LOW ? g : ~g;
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // In hex mode the raw value never shifts, so its nibbles are the digits.
    assign digits = key[12] ? {4'h0, value} : bcd;

    always_comb begin
        state_nxt     = state;
        key_nxt       = key;
        key_valid_nxt = key_valid;
        value_nxt     = value;
        bcd_nxt       = bcd;
        bit_cnt_nxt   = bit_cnt;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        hex0_nxt      = HEX_0;
        hex1_nxt      = HEX_1;
        hex2_nxt      = HEX_2;
        hex3_nxt      = HEX_3;

        case (state)
            IDLE: begin
                if (!SW[15] && (!key_valid || sw_key != key)) begin
                    key_nxt     = sw_key;
                    value_nxt   = SW[11:0];
                    bcd_nxt     = 16'h0000;
                    bit_cnt_nxt = 4'd0;
                    busy_nxt    = 1'b1;
                    state_nxt   = SW[14] ? LATCH : SHIFT;
                end
            end
            SHIFT: begin
                {bcd_nxt, value_nxt} = {add3(bcd), value} << 1;
                bit_cnt_nxt = bit_cnt + 4'd1;
                if (bit_cnt == 4'd11) state_nxt = LATCH;
            end
            LATCH: begin
                hex0_nxt = glyph(digits[3:0]);
                hex1_nxt = (BLANK_LZ && digits[15:4] == 12'h000) ? BLANK : glyph(digits[7:4]);
                hex2_nxt = (BLANK_LZ && digits[15:8] == 8'h00) ? BLANK : glyph(digits[11:8]);
                hex3_nxt = (key[12] || (BLANK_LZ && digits[15:12] == 4'h0)) ? BLANK
                                                                             : glyph(digits[15:12]);
                key_valid_nxt = 1'b1;
                busy_nxt      = 1'b0;
                done_nxt      = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key       <= 13'h0000;
            key_valid <= 1'b0;
            value     <= 12'h000;
            bcd       <= 16'h0000;
            bit_cnt   <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            HEX_0     <= BLANK;
            HEX_1     <= BLANK;
            HEX_2     <= BLANK;
            HEX_3     <= BLANK;
        end else begin
            state     <= state_nxt;
            key       <= key_nxt;
            key_valid <= key_valid_nxt;
            value     <= value_nxt;
            bcd       <= bcd_nxt;
            bit_cnt   <= bit_cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            HEX_0     <= hex0_nxt;
            HEX_1     <= hex1_nxt;
            HEX_2     <= hex2_nxt;
            HEX_3     <= hex3_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: a countdown-style behavioural model is compared
// every cycle, plus hand-computed glyph and latency checks.
module tb_bcd_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] SW  = 16'd5;
    logic [6:0]  HEX_0, HEX_1, HEX_2, HEX_3;
    logic        busy, done;

    int passed = 0;
    int total  = 0;

    bcd_display_ctrl dut (
        .clk(clk), .rst(rst), .SW(SW),
        .HEX_0(HEX_0), .HEX_1(HEX_1), .HEX_2(HEX_2), .HEX_3(HEX_3),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [6:0] GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Expected {HEX_3,HEX_2,HEX_1,HEX_0} for a value, computed from decimal/hex digits.
    function automatic logic [27:0] expectHex(input int v, input bit hexMode);
        int d[4];
        int ms;
        logic [27:0] r;
        if (hexMode) begin
            d[3] = 0; d[2] = (v >> 8) & 15; d[1] = (v >> 4) & 15; d[0] = v & 15;
        end else begin
            d[3] = v / 1000; d[2] = (v / 100) % 10; d[1] = (v / 10) % 10; d[0] = v % 10;
        end
        ms = 0;
        for (int i = 0; i < 4; i++) if (d[i] != 0) ms = i;
        for (int i = 0; i < 4; i++)
            r[i*7 +: 7] = (i > ms || (hexMode && i == 3)) ? 7'h7F : GLYPH[d[i]];
        return r;
    endfunction

    logic [27:0] m_hex = {4{7'h7F}};
    logic        m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0, m_mode = 1'b0;
    logic [12:0] m_key = '0;
    int          m_val = 0, m_left = 0;
    bit          m_started = 1'b0;

    // Model: a capture arms a countdown of 13 (decimal) or 1 (hex) edges.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_started = 1'b1;
            m_hex = {4{7'h7F}};
            m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hex = expectHex(m_val, m_mode);
                m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end
        end else if (!SW[15] && (!m_valid || {SW[14], SW[11:0]} != m_key)) begin
            m_key = {SW[14], SW[11:0]};
            m_val = int'(SW[11:0]);
            m_mode = SW[14];
            m_left = m_mode ? 1 : 13;
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            total++;
            if ({HEX_3, HEX_2, HEX_1, HEX_0, busy, done} === {m_hex, m_busy, m_done})
                passed++;
            else
                $display("[TB] FAIL cycle_compare at %0t: got %h expected %h", $time,
                         {HEX_3, HEX_2, HEX_1, HEX_0, busy, done}, {m_hex, m_busy, m_done});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [15:0] sw);
        @(negedge clk);
        SW = sw;
    endtask

    task automatic waitDone(input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    int n;

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_state", {HEX_3, HEX_2, HEX_1, HEX_0, busy, done}, {{4{7'h7F}}, 2'b00});
        rst = 1'b0;
        waitDone(40, n);
        checkOutput("lat_dec_5", n, 14);
        checkOutput("hex_5", {HEX_3, HEX_2, HEX_1, HEX_0}, {7'h7F, 7'h7F, 7'h7F, 7'b0010010});
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);

        applyStimulus(16'd1698);
        waitDone(40, n);
        checkOutput("lat_dec_1698", n, 14);
        checkOutput("hex_1698", {HEX_3, HEX_2, HEX_1, HEX_0},
                    {7'b1111001, 7'b0000010, 7'b0010000, 7'b0000000});

        applyStimulus(16'd4095);
        waitDone(40, n);
        checkOutput("hex_4095", {HEX_3, HEX_2, HEX_1, HEX_0},
                    {7'b0011001, 7'b1000000, 7'b0010000, 7'b0010010});

        applyStimulus(16'd0);
        waitDone(40, n);
        checkOutput("hex_0", {HEX_3, HEX_2, HEX_1, HEX_0}, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});

        applyStimulus(16'h4ABC);
        waitDone(40, n);
        checkOutput("lat_hex_ABC", n, 2);
        checkOutput("hex_ABC", {HEX_3, HEX_2, HEX_1, HEX_0},
                    {7'h7F, 7'b0001000, 7'b0000011, 7'b1000110});

        applyStimulus(16'd25);
        repeat (5) @(negedge clk);
        SW = 16'd156;
        waitDone(40, n);
        checkOutput("hex_25_kept", {HEX_1, HEX_0}, {7'b0100100, 7'b0010010});
        waitDone(40, n);
        checkOutput("lat_recapture", n, 14);
        checkOutput("hex_156", {HEX_3, HEX_2, HEX_1, HEX_0},
                    {7'h7F, 7'b1111001, 7'b0010010, 7'b0000010});

        applyStimulus(16'h8000 | 16'd123);
        repeat (20) @(negedge clk);
        checkOutput("hold_no_busy", busy, 0);
        checkOutput("hold_hex_kept", HEX_0, 7'b0000010);
        applyStimulus(16'd123);
        @(negedge clk);
        checkOutput("release_busy", busy, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset", {HEX_3, HEX_2, HEX_1, HEX_0, busy, done}, {{4{7'h7F}}, 2'b00});
        rst = 1'b0;
        waitDone(40, n);
        checkOutput("lat_after_reset", n, 14);
        checkOutput("hex_123", {HEX_3, HEX_2, HEX_1, HEX_0},
                    {7'h7F, 7'b1111001, 7'b0100100, 7'b0110000});

        for (int i = 0; i < 250; i++) begin
            logic [15:0] sw;
            sw = 16'($urandom);
            if ($urandom_range(0, 3) != 0) sw[15] = 1'b0;
            applyStimulus(sw);
            repeat ($urandom_range(0, 18)) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        applyStimulus(16'd777);
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
